mips_pipeline_core: RTL and testbench
=====================================

# mips_pipeline_core

Five-stage (IF/ID/EX/MEM/WB) pipelined MIPS-lite core, the pipelined successor of the single-cycle datapath. It executes the same instruction subset and adds hazard detection, selectable operand forwarding, load-use stalling and branch flushing. Instruction and data memories sit outside the block on combinational-read ports. A retirement port lets the verification bench track architectural state.

## Interface
- PC_RESET, 32'h0000_0000, fetch address after reset
- FORWARDING, 1, 1 = EX operand bypass from EX/MEM and MEM/WB; 0 = no bypass, ID stalls on every RAW hazard

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- imem_addr  out  32  fetch PC
- imem_rdata  in  32  instruction at imem_addr, same cycle
- dmem_addr  out  32  MEM-stage ALU result
- dmem_wdata  out  32  MEM-stage store data
- dmem_we  out  1  store strobe, written at rising clk
- dmem_re  out  1  load strobe
- dmem_rdata  in  32  load data at dmem_addr, same cycle
- wb_valid  out  1  one instruction retires this cycle
- wb_pc  out  32  PC of retiring instruction
- wb_we  out  1  retiring instruction writes a register (never for $0)
- wb_reg  out  5  destination register
- wb_data  out  32  value written

## Operation
- Supported instructions:
  - R-type (op 0x00), funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04.
  - Any other opcode or funct is a valid no-op: it retires with wb_we=0.
- Arithmetic is 32-bit, wraps and ignores overflow. Immediates are sign-extended. Branch target = PC+4 + (sext(imm)<<2), mod 2^32. PC increments by 4, mod 2^32.
- Register file:
  - 32x32, two read ports in ID, one write port in WB.
  - A WB write to the register being read in ID is visible the same cycle (write-through).
  - $0 always reads 0.
  - Cleared to 0 on reset.
- Forwarding (FORWARDING=1): an EX source takes data from EX/MEM (priority) or MEM/WB when that stage writes the same non-zero register. sw store data is forwarded the same way.
- Load-use hazard (either mode): lw in EX whose rt matches a source of the instruction in ID triggers a 1-cycle stall:
  - PC and IF/ID hold.
  - A bubble goes into ID/EX.
- FORWARDING=0: ID stalls while the EX or MEM stage holds a pending write to either non-zero source register. WB is covered by write-through.
- beq is resolved in EX. If taken:
  - The IF/ID and ID/EX contents are flushed to bubbles.
  - The PC loads the target.
  - The penalty is 2 cycles.
  - If taken and a stall occur in the same cycle, the flush wins and the stall is dropped.
- Bubbles never assert dmem_we, dmem_re or wb_valid.

## Timing
- Reset values, applied immediately on assertion regardless of clk:
  - imem_addr = PC_RESET.
  - All stage valid bits 0.
  - dmem_we = dmem_re = 0.
  - wb_valid = wb_we = 0; wb_pc, wb_reg, wb_data = 0.
- Reset mid-operation discards every in-flight instruction. Any store pending in MEM is not performed.
- The first rising edge after reset deasserts fetches PC_RESET.
- Instruction fetched in cycle n retires (wb_valid=1) in cycle n+4, plus stall cycles.
- Throughput is 1 instruction/cycle when hazard-free.
- Extra latency:
  - Load-use: +1 cycle.
  - Taken beq: 2 lost slots.
  - FORWARDING=0 dependent pair: back-to-back dependency adds +2 cycles; one instruction apart adds +1.
- Retirement port outputs are driven from the MEM/WB register; they are valid during the WB cycle.

## Test plan
- Forwarding: reset, then addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 with FORWARDING=1. Required: three consecutive wb_valid cycles; the last has wb_reg=3, wb_data=12.
- No forwarding: repeat the previous program with FORWARDING=0. Required: add retires 2 cycles later than with FORWARDING=1, wb_data=12.
- Load-use: dmem[0]=0xDEADBEEF; lw $4,0($0); add $5,$4,$4. Required: exactly one bubble (a wb_valid=0 cycle) between the two retirements; $5 = 0xBD5B7DDE.
- Taken branch: beq $0,$0,+2 followed by two addi instructions. Required: neither addi retires; next wb_pc = branch PC+12; wb_valid=0 for exactly 2 cycles after beq retires.
- Store forwarding and $0: addi $6,$0,0x55; sw $6,8($0). Required: dmem_we=1 with dmem_addr=8, dmem_wdata=0x55. Then addi $0,$0,9. Required: wb_valid=1, wb_we=0, and a later read of $0 returns 0.
- Reset mid-run: assert reset asynchronously while sw is in MEM. Required: dmem_we falls to 0 and imem_addr becomes PC_RESET immediately, without a clock edge; the store is never performed.

Source files
------------

// File: rtl/mips_pipeline_core.sv
// Five-stage pipelined MIPS-lite core (add/sub/and/or/slt, addi, lw, sw, beq; other encodings retire as no-ops).
// Latency: fetch to retire 4 cycles; +1 load-use, 2 lost slots per taken beq, +1/+2 RAW stalls when FORWARDING=0.
// Backpressure: no external stall; internal hazards hold PC and IF/ID and inject bubbles into ID/EX.
module mips_pipeline_core #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000,
    parameter int          FORWARDING = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_we,
    output logic        dmem_re,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic        wb_we,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic        we;       // writes a non-zero register
        logic        mem_rd;
        logic        mem_wr;
        logic        branch;
        logic        alu_src;  // 1: second ALU operand is the immediate
        alu_op_t     alu_op;
    } idex_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] sdat;
        logic [4:0]  dest;
        logic        we;
        logic        mem_rd;
        logic        mem_wr;
    } exmem_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] dat;
    } memwb_t;

    logic [31:0] pc;
    ifid_t       ifid;
    idex_t       idex;
    exmem_t      exmem;
    memwb_t      memwb;
    logic [31:0] rf [32];

    idex_t       dec;
    exmem_t      ex_nxt;
    memwb_t      mem_nxt;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        use_rs;
    logic        use_rt;
    logic [31:0] rd_rs;
    logic [31:0] rd_rt;
    logic        load_use;
    logic        raw_ex;
    logic        raw_mem;
    logic        stall;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic        taken;
    logic [31:0] target;
    logic        unused_bits;

    assign id_rs = ifid.instr[25:21];
    assign id_rt = ifid.instr[20:16];
    assign unused_bits = ^ifid.instr[10:6];

    // Register read with write-through so a same-cycle WB write is seen by ID
    assign rd_rs = (id_rs == 5'd0) ? 32'd0 :
                   (memwb.vld && memwb.we && memwb.dest == id_rs) ? memwb.dat : rf[id_rs];
    assign rd_rt = (id_rt == 5'd0) ? 32'd0 :
                   (memwb.vld && memwb.we && memwb.dest == id_rt) ? memwb.dat : rf[id_rt];

    // Decode the ID instruction into ID/EX control and operands
    always_comb begin
        dec     = '0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        dec.vld    = ifid.vld;
        dec.pc     = ifid.pc;
        dec.rs     = id_rs;
        dec.rt     = id_rt;
        dec.imm    = {{16{ifid.instr[15]}}, ifid.instr[15:0]};
        dec.rs_val = rd_rs;
        dec.rt_val = rd_rt;
        dec.alu_op = ALU_ADD;
        case (ifid.instr[31:26])
            OP_RTYPE: begin
                dec.dest = ifid.instr[15:11];
                dec.we   = 1'b1;
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                case (ifid.instr[5:0])
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_SLT:  dec.alu_op = ALU_SLT;
                    default: begin
                        dec.we = 1'b0;
                        use_rs = 1'b0;
                        use_rt = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                dec.dest    = id_rt;
                dec.we      = 1'b1;
                dec.alu_src = 1'b1;
                use_rs      = 1'b1;
            end
            OP_LW: begin
                dec.dest    = id_rt;
                dec.we      = 1'b1;
                dec.mem_rd  = 1'b1;
                dec.alu_src = 1'b1;
                use_rs      = 1'b1;
            end
            OP_SW: begin
                dec.mem_wr  = 1'b1;
                dec.alu_src = 1'b1;
                use_rs      = 1'b1;
                use_rt      = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
                use_rs     = 1'b1;
                use_rt     = 1'b1;
            end
            default: ;
        endcase
        // $0 is never a destination: suppress the write entirely
        dec.we = dec.we && (dec.dest != 5'd0);
        if (!ifid.vld) begin
            dec    = '0;
            use_rs = 1'b0;
            use_rt = 1'b0;
        end
    end

    // Hazard detection: load-use always, every in-flight RAW when bypass is off
    always_comb begin
        load_use = idex.vld && idex.mem_rd && idex.we &&
                   ((use_rs && idex.dest == id_rs) || (use_rt && idex.dest == id_rt));
        raw_ex   = idex.vld && idex.we &&
                   ((use_rs && idex.dest == id_rs) || (use_rt && idex.dest == id_rt));
        raw_mem  = exmem.vld && exmem.we &&
                   ((use_rs && exmem.dest == id_rs) || (use_rt && exmem.dest == id_rt));
        stall    = ifid.vld && (load_use || ((FORWARDING == 0) && (raw_ex || raw_mem)));
    end

    // EX stage: operand bypass (EX/MEM wins over MEM/WB), ALU, branch resolution
    always_comb begin
        fwd_a = idex.rs_val;
        fwd_b = idex.rt_val;
        if (FORWARDING != 0) begin
            if (exmem.vld && exmem.we && exmem.dest == idex.rs)
                fwd_a = exmem.alu;
            else if (memwb.vld && memwb.we && memwb.dest == idex.rs)
                fwd_a = memwb.dat;
            if (exmem.vld && exmem.we && exmem.dest == idex.rt)
                fwd_b = exmem.alu;
            else if (memwb.vld && memwb.we && memwb.dest == idex.rt)
                fwd_b = memwb.dat;
        end
        alu_b = idex.alu_src ? idex.imm : fwd_b;
        case (idex.alu_op)
            ALU_ADD: alu_y = fwd_a + alu_b;
            ALU_SUB: alu_y = fwd_a - alu_b;
            ALU_AND: alu_y = fwd_a & alu_b;
            ALU_OR:  alu_y = fwd_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            default: alu_y = fwd_a + alu_b;
        endcase
        taken  = idex.vld && idex.branch && (fwd_a == fwd_b);
        target = idex.pc + 32'd4 + {idex.imm[29:0], 2'b00};

        ex_nxt        = '0;
        ex_nxt.vld    = idex.vld;
        ex_nxt.pc     = idex.pc;
        ex_nxt.alu    = alu_y;
        ex_nxt.sdat   = fwd_b;
        ex_nxt.dest   = idex.dest;
        ex_nxt.we     = idex.we;
        ex_nxt.mem_rd = idex.mem_rd;
        ex_nxt.mem_wr = idex.mem_wr;
        if (!idex.vld)
            ex_nxt = '0;
    end

    // MEM stage: select load data or ALU result for writeback
    always_comb begin
        mem_nxt      = '0;
        mem_nxt.vld  = exmem.vld;
        mem_nxt.pc   = exmem.pc;
        mem_nxt.we   = exmem.we;
        mem_nxt.dest = exmem.dest;
        mem_nxt.dat  = exmem.mem_rd ? dmem_rdata : exmem.alu;
        if (!exmem.vld)
            mem_nxt = '0;
    end

    // PC and pipeline registers; a taken branch overrides a concurrent stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= PC_RESET;
            ifid  <= '0;
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
        end else begin
            if (taken) begin
                pc   <= target;
                ifid <= '0;
                idex <= '0;
            end else if (stall) begin
                idex <= '0;
            end else begin
                pc         <= pc + 32'd4;
                ifid.vld   <= 1'b1;
                ifid.pc    <= pc;
                ifid.instr <= imem_rdata;
                idex       <= dec;
            end
            exmem <= ex_nxt;
            memwb <= mem_nxt;
        end
    end

    // Register file write port in WB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= 32'd0;
        end else if (memwb.vld && memwb.we) begin
            rf[memwb.dest] <= memwb.dat;
        end
    end

    assign imem_addr  = pc;
    assign dmem_addr  = exmem.alu;
    assign dmem_wdata = exmem.sdat;
    assign dmem_we    = exmem.vld && exmem.mem_wr;
    assign dmem_re    = exmem.vld && exmem.mem_rd;
    assign wb_valid   = memwb.vld;
    assign wb_pc      = memwb.pc;
    assign wb_we      = memwb.vld && memwb.we;
    assign wb_reg     = memwb.dest;
    assign wb_data    = memwb.dat;

endmodule

// File: tb/tb_mips_pipeline_core.sv
module tb_mips_pipeline_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // bypass-enabled core
    logic [31:0] f_imem_addr, f_imem_rdata, f_dmem_addr, f_dmem_wdata, f_dmem_rdata, f_wb_pc, f_wb_data;
    logic        f_dmem_we, f_dmem_re, f_wb_valid, f_wb_we;
    logic [4:0]  f_wb_reg;
    // bypass-disabled core
    logic [31:0] n_imem_addr, n_imem_rdata, n_dmem_addr, n_dmem_wdata, n_dmem_rdata, n_wb_pc, n_wb_data;
    logic        n_dmem_we, n_dmem_re, n_wb_valid, n_wb_we;
    logic [4:0]  n_wb_reg;

    logic [31:0] imem_f [32];
    logic [31:0] imem_n [32];
    logic [31:0] dmem_f [16] = '{0: 32'hDEADBEEF, default: 32'h0};
    logic [31:0] dmem_n [16] = '{default: 32'h0};
    int          st_cnt = 0;

    assign f_imem_rdata = imem_f[f_imem_addr[6:2]];
    assign n_imem_rdata = imem_n[n_imem_addr[6:2]];
    assign f_dmem_rdata = dmem_f[f_dmem_addr[5:2]];
    assign n_dmem_rdata = dmem_n[n_dmem_addr[5:2]];

    // data memory write ports
    always @(posedge clk) begin
        if (f_dmem_we) begin
            dmem_f[f_dmem_addr[5:2]] <= f_dmem_wdata;
            st_cnt <= st_cnt + 1;
        end
        if (n_dmem_we)
            dmem_n[n_dmem_addr[5:2]] <= n_dmem_wdata;
    end

    mips_pipeline_core #(.PC_RESET(32'h0), .FORWARDING(1)) u_fwd (
        .clk(clk), .reset(reset),
        .imem_addr(f_imem_addr), .imem_rdata(f_imem_rdata),
        .dmem_addr(f_dmem_addr), .dmem_wdata(f_dmem_wdata), .dmem_we(f_dmem_we),
        .dmem_re(f_dmem_re), .dmem_rdata(f_dmem_rdata),
        .wb_valid(f_wb_valid), .wb_pc(f_wb_pc), .wb_we(f_wb_we), .wb_reg(f_wb_reg), .wb_data(f_wb_data)
    );

    mips_pipeline_core #(.PC_RESET(32'h0), .FORWARDING(0)) u_nof (
        .clk(clk), .reset(reset),
        .imem_addr(n_imem_addr), .imem_rdata(n_imem_rdata),
        .dmem_addr(n_dmem_addr), .dmem_wdata(n_dmem_wdata), .dmem_we(n_dmem_we),
        .dmem_re(n_dmem_re), .dmem_rdata(n_dmem_rdata),
        .wb_valid(n_wb_valid), .wb_pc(n_wb_pc), .wb_we(n_wb_we), .wb_reg(n_wb_reg), .wb_data(n_wb_data)
    );

    typedef struct packed {
        logic        v;
        logic        we;
        logic [4:0]  rg;
        logic [31:0] pc;
        logic [31:0] dat;
        logic        dwe;
        logic        dre;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic [31:0] ia;
    } smp_t;

    smp_t tr_f [17];
    smp_t tr_n [17];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sample(input int k);
        tr_f[k] = '{f_wb_valid, f_wb_we, f_wb_reg, f_wb_pc, f_wb_data,
                    f_dmem_we, f_dmem_re, f_dmem_addr, f_dmem_wdata, f_imem_addr};
        tr_n[k] = '{n_wb_valid, n_wb_we, n_wb_reg, n_wb_pc, n_wb_data,
                    n_dmem_we, n_dmem_re, n_dmem_addr, n_dmem_wdata, n_imem_addr};
    endtask

    initial begin
        logic hit_flushed;
        for (int i = 0; i < 32; i++) begin
            imem_f[i] = 32'h0;
            imem_n[i] = 32'h0;
        end
        imem_f[0]  = 32'h20010005; // addi $1,$0,5
        imem_f[1]  = 32'h20020007; // addi $2,$0,7
        imem_f[2]  = 32'h00221820; // add  $3,$1,$2
        imem_f[3]  = 32'h8C040000; // lw   $4,0($0)
        imem_f[4]  = 32'h00842820; // add  $5,$4,$4
        imem_f[5]  = 32'h10000002; // beq  $0,$0,+2 -> 32
        imem_f[6]  = 32'h20070001; // addi $7,$0,1 (flushed)
        imem_f[7]  = 32'h20080001; // addi $8,$0,1 (flushed)
        imem_f[8]  = 32'h20060055; // addi $6,$0,0x55
        imem_f[9]  = 32'hAC060008; // sw   $6,8($0)
        imem_f[10] = 32'h20000009; // addi $0,$0,9
        imem_f[11] = 32'h00004820; // add  $9,$0,$0
        imem_n[0]  = 32'h20010005;
        imem_n[1]  = 32'h20020007;
        imem_n[2]  = 32'h00221820;

        // reset state, sampled well away from any edge
        #1;
        check("rst_imem_addr", f_imem_addr, 32'h0);
        check("rst_dmem_we", 32'(f_dmem_we), 32'd0);
        check("rst_dmem_re", 32'(f_dmem_re), 32'd0);
        check("rst_wb_valid", 32'(f_wb_valid), 32'd0);
        check("rst_wb_we", 32'(f_wb_we), 32'd0);
        check("rst_wb_pc", f_wb_pc, 32'h0);
        check("rst_wb_reg", 32'(f_wb_reg), 32'd0);
        check("rst_wb_data", f_wb_data, 32'h0);

        tick();
        reset = 1'b0;
        sample(0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            sample(k);
        end

        // fetch sequence
        check("fetch0_addr", tr_f[0].ia, 32'h0);
        check("fetch1_addr", tr_f[1].ia, 32'h4);

        // bypass program: three back-to-back retirements
        check("fwd_r4_v", 32'(tr_f[4].v), 32'd1);
        check("fwd_r4_dat", tr_f[4].dat, 32'd5);
        check("fwd_r5_v", 32'(tr_f[5].v), 32'd1);
        check("fwd_r5_dat", tr_f[5].dat, 32'd7);
        check("fwd_add_v", 32'(tr_f[6].v), 32'd1);
        check("fwd_add_reg", 32'(tr_f[6].rg), 32'd3);
        check("fwd_add_dat", tr_f[6].dat, 32'd12);

        // load-use: lw retires, one bubble, dependent add retires
        check("lw_dmem_re", 32'(tr_f[6].dre), 32'd1);
        check("lw_ret_v", 32'(tr_f[7].v), 32'd1);
        check("lw_ret_dat", tr_f[7].dat, 32'hDEADBEEF);
        check("lu_bubble", 32'(tr_f[8].v), 32'd0);
        check("lu_add_v", 32'(tr_f[9].v), 32'd1);
        check("lu_add_reg", 32'(tr_f[9].rg), 32'd5);
        check("lu_add_dat", tr_f[9].dat, 32'hBD5B7DDE);

        // taken branch: two empty slots, next retirement at branch PC + 12
        check("beq_ret_pc", tr_f[10].pc, 32'd20);
        check("beq_ret_we", 32'(tr_f[10].we), 32'd0);
        check("beq_gap1", 32'(tr_f[11].v), 32'd0);
        check("beq_gap2", 32'(tr_f[12].v), 32'd0);
        check("beq_next_v", 32'(tr_f[13].v), 32'd1);
        check("beq_next_pc", tr_f[13].pc, 32'd32);
        hit_flushed = 1'b0;
        for (int k = 0; k <= 16; k++)
            if (tr_f[k].v && (tr_f[k].pc == 32'd24 || tr_f[k].pc == 32'd28))
                hit_flushed = 1'b1;
        check("flushed_retired", 32'(hit_flushed), 32'd0);

        // store with forwarded data
        check("sw_we", 32'(tr_f[13].dwe), 32'd1);
        check("sw_addr", tr_f[13].daddr, 32'd8);
        check("sw_wdata", tr_f[13].dwd, 32'h55);
        check("sw_mem", dmem_f[2], 32'h55);

        // writes to $0 are discarded
        check("r0_ret_v", 32'(tr_f[15].v), 32'd1);
        check("r0_ret_we", 32'(tr_f[15].we), 32'd0);
        check("r0_read_reg", 32'(tr_f[16].rg), 32'd9);
        check("r0_read_we", 32'(tr_f[16].we), 32'd1);
        check("r0_read_dat", tr_f[16].dat, 32'd0);

        // no bypass: dependent add retires two cycles later
        check("nof_r4_v", 32'(tr_n[4].v), 32'd1);
        check("nof_r5_v", 32'(tr_n[5].v), 32'd1);
        check("nof_gap6", 32'(tr_n[6].v), 32'd0);
        check("nof_gap7", 32'(tr_n[7].v), 32'd0);
        check("nof_add_v", 32'(tr_n[8].v), 32'd1);
        check("nof_add_reg", 32'(tr_n[8].rg), 32'd3);
        check("nof_add_dat", tr_n[8].dat, 32'd12);

        check("store_count_run1", 32'(st_cnt), 32'd1);

        // second run: reset asynchronously while sw sits in MEM
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 13; k++)
            tick();
        check("run2_sw_in_mem", 32'(f_dmem_we), 32'd1);
        check("run2_sw_addr", f_dmem_addr, 32'd8);
        #2;
        reset = 1'b1;
        #1;
        check("async_dmem_we", 32'(f_dmem_we), 32'd0);
        check("async_imem_addr", f_imem_addr, 32'h0);
        check("async_wb_valid", 32'(f_wb_valid), 32'd0);
        tick();
        check("store_count_run2", 32'(st_cnt), 32'd1);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
